multicycle_control: RTL and testbench
=====================================

# multicycle_control

Parametrised multi-cycle control unit for the RV32I core. It replaces the single-cycle decoder with a state machine that sequences fetch, decode, execute, memory and writeback over several cycles. It handshakes with a shared instruction/data memory that may insert wait states, and traps on illegal opcodes or memory timeouts. It also keeps a retired-instruction counter. It sits between the instruction register and the multi-cycle datapath (PC, IR, ALUOut, MDR registers and source muxes).

## Interface
- TIMEOUT, 16: maximum cycles to wait for `mem_ready` on one request; 0 disables the timeout.
- CNT_W, 32: width of the retired-instruction counter.
- clk  in  1  sole clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- instr  in  32  current IR contents; opcode class is `instr[6:2]`.
- mem_ready  in  1  memory completed the current request this cycle.
- mem_req  out  1  memory request; held until `mem_ready`.
- mem_we  out  1  write qualifier for `mem_req`.
- adr_src  out  1  memory address: 0 = PC, 1 = ALUOut.
- ir_write  out  1  load IR from memory read data.
- pc_write  out  1  unconditional PC update.
- branch  out  1  conditional PC update; the datapath computes `pc_en = pc_write | (branch & zero)`.
- reg_write  out  1  register file write.
- alu_src_a  out  2  ALU A source: 00 PC, 01 oldPC, 10 rs1, 11 zero.
- alu_src_b  out  2  ALU B source: 00 rs2, 01 imm, 10 constant 4.
- alu_op  out  2  00 add, 01 branch compare, 10 R-type funct decode, 11 I-type funct decode.
- result_src  out  2  writeback/PC source: 00 ALUOut, 01 MDR, 10 ALU result direct.
- illegal  out  1  sticky trap: unknown opcode.
- bus_err  out  1  sticky trap: memory timeout.
- instret  out  CNT_W  retired-instruction count.

## Operation
- States: RST, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH, JALR_ADR, JUMP, LUI, AUIPC, TRAP.
- Outputs are Moore (decoded from state only), except `ir_write` and `pc_write` in FETCH, which equal `mem_ready`.
- Any output not listed for a state is 0.
- RST: all outputs 0. Next state FETCH unconditionally.
- FETCH: `mem_req`, `adr_src=0`, A=00, B=10, `alu_op=00`, `result_src=10`.
  - Stays in FETCH until `mem_ready`, then goes to DECODE.
- DECODE: A=01, B=01, `alu_op=00` (branch/JAL target into ALUOut). Next state by `instr[6:2]`:
  - 01100 → EXECR.
  - 00100 → EXECI.
  - 00000 or 01000 → MEMADR.
  - 11000 → BRANCH.
  - 11011 (JAL) → JUMP.
  - 11001 (JALR) → JALR_ADR.
  - 01101 → LUI.
  - 00101 → AUIPC.
  - any other value → TRAP with `illegal` set.
- MEMADR: A=10, B=01, `alu_op=00`. Goes to MEMRD if opcode is 00000, else MEMWR.
- MEMRD: `mem_req`, `adr_src=1`. Waits for `mem_ready`, then MEMWB.
- MEMWB: `reg_write`, `result_src=01`. Goes to FETCH.
- MEMWR: `mem_req`, `mem_we`, `adr_src=1`. Waits for `mem_ready`, then FETCH.
- EXECR: A=10, B=00, `alu_op=10`. Goes to ALUWB.
- EXECI: A=10, B=01, `alu_op=11`. Goes to ALUWB.
- LUI: A=11, B=01, `alu_op=00`. Goes to ALUWB.
- AUIPC: A=01, B=01, `alu_op=00`. Goes to ALUWB.
- ALUWB: `reg_write`, `result_src=00`. Goes to FETCH.
- BRANCH: A=10, B=00, `alu_op=01`, `result_src=00`, `branch`. Goes to FETCH.
- JALR_ADR: A=10, B=01, `alu_op=00` (target into ALUOut). Goes to JUMP.
- JUMP: A=01, B=10, `alu_op=00`, `result_src=00`, `pc_write`. Goes to ALUWB, which writes oldPC+4 to rd.
- TRAP: all outputs 0 except `illegal`/`bus_err`. Absorbing; only reset exits.
- Wait counter:
  - Cleared on entry to FETCH, MEMRD and MEMWR.
  - Increments each cycle `mem_req` is high and `mem_ready` is low.
  - If TIMEOUT>0 and the counter reaches TIMEOUT with `mem_ready` still low: set `bus_err`, go to TRAP.
  - `mem_ready` in the same cycle as the timeout wins; no trap.
- `instret` increments by 1 on every transition into FETCH from a state other than RST. It wraps modulo 2^CNT_W.

## Timing
- Reset values: state RST; `illegal=0`, `bus_err=0`, `instret=0`, wait counter 0; all outputs 0.
- Asserting `rst_n` low mid-instruction returns to RST immediately. No partial write completes after the reset edge.
- First `mem_req` is in the second cycle after `rst_n` deasserts.
- Cycles per instruction with zero-wait memory (`mem_ready` high on the first request cycle):
  - branch 3.
  - R-type, I-ALU, LUI, AUIPC, store 4.
  - JAL 4.
  - load 5.
  - JALR 5.
- Each memory wait cycle adds 1.
- `mem_req`, `mem_we` and `adr_src` are stable for the whole request, until and including the `mem_ready` cycle.
- `mem_ready` while `mem_req` is low is ignored.

## Test plan
- Reset, then ADD (opcode 0110011), `mem_ready` always 1:
  - state sequence RST, FETCH, DECODE, EXECR, ALUWB, FETCH.
  - `reg_write` high exactly once.
  - `instret`=1 on return to FETCH.
- LW with 3 wait cycles in both FETCH and MEMRD:
  - `mem_req` held 4 cycles each time, `adr_src` 0 then 1.
  - total 11 cycles; `result_src=01` in the write cycle.
- SW then BEQ:
  - SW: `mem_we` only in MEMWR; no `reg_write`.
  - BEQ: `branch`=1 for exactly one cycle, `pc_write`=0; 3 cycles.
- JAL and JALR: `pc_write` in JUMP, then `reg_write` with A=01, B=10; JALR takes 5 cycles.
- Illegal opcode 1111111 in DECODE:
  - `illegal`=1 next cycle and stays; no `mem_req` thereafter.
  - `rst_n` pulse clears `illegal` and `instret`.
- TIMEOUT=4, `mem_ready` held 0 in FETCH: `bus_err`=1 after 4 request cycles, TRAP entered. `mem_ready` arriving exactly on cycle 4 causes no trap.

Source files
------------

// File: rtl/multicycle_control.sv
// Multi-cycle control FSM for the RV32I core.
// Sequences fetch/decode/execute/memory/writeback, handshakes with a shared
// memory that may stall, traps on unknown opcodes or memory timeouts, and
// counts retired instructions.
module multicycle_control #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      instr,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             adr_src,
  output logic             ir_write,
  output logic             pc_write,
  output logic             branch,
  output logic             reg_write,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       result_src,
  output logic             illegal,
  output logic             bus_err,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [3:0] {
    S_RST, S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXECR,
    S_EXECI, S_ALUWB, S_BRANCH, S_JALR_ADR, S_JUMP, S_LUI, S_AUIPC, S_TRAP
  } state_e;

  // Control word held in flops so every Moore output comes straight from a register.
  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       adr_src;
    logic       fetch;
    logic       pc_write;
    logic       branch;
    logic       reg_write;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] result_src;
  } ctrl_t;

  localparam logic [4:0] OPC_LOAD   = 5'b00000;
  localparam logic [4:0] OPC_STORE  = 5'b01000;
  localparam logic [4:0] OPC_RTYPE  = 5'b01100;
  localparam logic [4:0] OPC_ITYPE  = 5'b00100;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_JAL    = 5'b11011;
  localparam logic [4:0] OPC_JALR   = 5'b11001;
  localparam logic [4:0] OPC_LUI    = 5'b01101;
  localparam logic [4:0] OPC_AUIPC  = 5'b00101;

  // Counter only has to reach TIMEOUT-1; a disabled timeout lets it wrap harmlessly.
  localparam int               WAIT_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam bit               TO_EN     = (TIMEOUT > 0);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

  state_e             state_q, state_d;
  ctrl_t              ctrl_q, ctrl_d;
  logic               illegal_q, illegal_d;
  logic               bus_err_q, bus_err_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [CNT_W-1:0]   instret_q, instret_d;
  logic [4:0]         opc_s;
  logic               timeout_s;
  logic               req_entry_s;
  logic               unused_instr_bits;

  assign opc_s             = instr[6:2];
  assign unused_instr_bits = ^{instr[31:7], instr[1:0]};

  // Moore decode of the control word for a given state.
  function automatic ctrl_t decode_ctrl(input state_e s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.mem_req    = 1'b1;
        c.fetch      = 1'b1;
        c.alu_src_b  = 2'b10;
        c.result_src = 2'b10;
      end
      S_DECODE: begin
        c.alu_src_a = 2'b01;
        c.alu_src_b = 2'b01;
      end
      S_MEMADR: begin
        c.alu_src_a = 2'b10;
        c.alu_src_b = 2'b01;
      end
      S_MEMRD: begin
        c.mem_req = 1'b1;
        c.adr_src = 1'b1;
      end
      S_MEMWB: begin
        c.reg_write  = 1'b1;
        c.result_src = 2'b01;
      end
      S_MEMWR: begin
        c.mem_req = 1'b1;
        c.mem_we  = 1'b1;
        c.adr_src = 1'b1;
      end
      S_EXECR: begin
        c.alu_src_a = 2'b10;
        c.alu_op    = 2'b10;
      end
      S_EXECI: begin
        c.alu_src_a = 2'b10;
        c.alu_src_b = 2'b01;
        c.alu_op    = 2'b11;
      end
      S_LUI: begin
        c.alu_src_a = 2'b11;
        c.alu_src_b = 2'b01;
      end
      S_AUIPC: begin
        c.alu_src_a = 2'b01;
        c.alu_src_b = 2'b01;
      end
      S_ALUWB: begin
        c.reg_write = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a = 2'b10;
        c.alu_op    = 2'b01;
        c.branch    = 1'b1;
      end
      S_JALR_ADR: begin
        c.alu_src_a = 2'b10;
        c.alu_src_b = 2'b01;
      end
      S_JUMP: begin
        c.alu_src_a = 2'b01;
        c.alu_src_b = 2'b10;
        c.pc_write  = 1'b1;
      end
      default: begin
        c = '0;
      end
    endcase
    return c;
  endfunction

  // Timeout fires when the last allowed wait cycle passes without mem_ready.
  assign timeout_s = TO_EN && ctrl_q.mem_req && !mem_ready && (wait_q == WAIT_LAST);

  // Next-state, sticky trap flags, wait counter and retire counter.
  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    bus_err_d = bus_err_q;
    case (state_q)
      S_RST: state_d = S_FETCH;
      S_FETCH: begin
        if (mem_ready) begin
          state_d = S_DECODE;
        end else if (timeout_s) begin
          state_d   = S_TRAP;
          bus_err_d = 1'b1;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_DECODE: begin
        case (opc_s)
          OPC_RTYPE:           state_d = S_EXECR;
          OPC_ITYPE:           state_d = S_EXECI;
          OPC_LOAD, OPC_STORE: state_d = S_MEMADR;
          OPC_BRANCH:          state_d = S_BRANCH;
          OPC_JAL:             state_d = S_JUMP;
          OPC_JALR:            state_d = S_JALR_ADR;
          OPC_LUI:             state_d = S_LUI;
          OPC_AUIPC:           state_d = S_AUIPC;
          default: begin
            state_d   = S_TRAP;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        if (opc_s == OPC_LOAD) begin
          state_d = S_MEMRD;
        end else begin
          state_d = S_MEMWR;
        end
      end
      S_MEMRD: begin
        if (mem_ready) begin
          state_d = S_MEMWB;
        end else if (timeout_s) begin
          state_d   = S_TRAP;
          bus_err_d = 1'b1;
        end else begin
          state_d = S_MEMRD;
        end
      end
      S_MEMWR: begin
        if (mem_ready) begin
          state_d = S_FETCH;
        end else if (timeout_s) begin
          state_d   = S_TRAP;
          bus_err_d = 1'b1;
        end else begin
          state_d = S_MEMWR;
        end
      end
      S_MEMWB, S_ALUWB, S_BRANCH: state_d = S_FETCH;
      S_EXECR, S_EXECI, S_LUI, S_AUIPC: state_d = S_ALUWB;
      S_JALR_ADR: state_d = S_JUMP;
      S_JUMP:     state_d = S_ALUWB;
      S_TRAP:     state_d = S_TRAP;
      default:    state_d = S_RST;
    endcase

    req_entry_s = (state_d != state_q) &&
                  ((state_d == S_FETCH) || (state_d == S_MEMRD) || (state_d == S_MEMWR));
    if (req_entry_s) begin
      wait_d = '0;
    end else if (ctrl_q.mem_req && !mem_ready) begin
      wait_d = wait_q + WAIT_W'(1);
    end else begin
      wait_d = wait_q;
    end

    if ((state_d == S_FETCH) && (state_q != S_FETCH) && (state_q != S_RST)) begin
      instret_d = instret_q + CNT_W'(1);
    end else begin
      instret_d = instret_q;
    end

    ctrl_d = decode_ctrl(state_d);
  end

  // State, registered control word, trap flags and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_RST;
      ctrl_q    <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
      wait_q    <= '0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      ctrl_q    <= ctrl_d;
      illegal_q <= illegal_d;
      bus_err_q <= bus_err_d;
      wait_q    <= wait_d;
      instret_q <= instret_d;
    end
  end

  assign mem_req    = ctrl_q.mem_req;
  assign mem_we     = ctrl_q.mem_we;
  assign adr_src    = ctrl_q.adr_src;
  // IR load and PC+4 happen on the cycle the fetch completes.
  assign ir_write   = ctrl_q.fetch & mem_ready;
  assign pc_write   = ctrl_q.pc_write | (ctrl_q.fetch & mem_ready);
  assign branch     = ctrl_q.branch;
  assign reg_write  = ctrl_q.reg_write;
  assign alu_src_a  = ctrl_q.alu_src_a;
  assign alu_src_b  = ctrl_q.alu_src_b;
  assign alu_op     = ctrl_q.alu_op;
  assign result_src = ctrl_q.result_src;
  assign illegal    = illegal_q;
  assign bus_err    = bus_err_q;
  assign instret    = instret_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: each instruction class is
// expanded into its expected per-cycle control words from the phase list of
// that class, with randomized memory wait states and random mem_ready noise
// outside requests.
module tb_multicycle_control;

  localparam int TO   = 4;
  localparam int CW   = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [31:0]   instr = '0;
  logic          mem_ready = 1'b0;
  logic          mem_req, mem_we, adr_src, ir_write, pc_write, branch, reg_write;
  logic [1:0]    alu_src_a, alu_src_b, alu_op, result_src;
  logic          illegal, bus_err;
  logic [CW-1:0] instret;

  int            checks = 0;
  int            errors = 0;
  logic          exp_ill = 1'b0;
  logic          exp_berr = 1'b0;
  int            exp_ir = 0;

  multicycle_control #(.TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .adr_src(adr_src), .ir_write(ir_write),
    .pc_write(pc_write), .branch(branch), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .result_src(result_src), .illegal(illegal), .bus_err(bus_err), .instret(instret)
  );

  always #5 clk = ~clk;

  // Control word: {mem_req, mem_we, adr_src, ir_write, pc_write, branch, reg_write, A, B, op, res}
  function automatic logic [14:0] cw(input logic mreq, mwe, adr, irw, pcw, br, rw,
                                     input logic [1:0] a, b, op, rs);
    return {mreq, mwe, adr, irw, pcw, br, rw, a, b, op, rs};
  endfunction

  localparam logic [14:0] W_ZERO  = 15'd0;
  localparam logic [14:0] W_FWAIT = {7'b1000000, 2'b00, 2'b10, 2'b00, 2'b10};
  localparam logic [14:0] W_FDONE = {7'b1001100, 2'b00, 2'b10, 2'b00, 2'b10};
  localparam logic [14:0] W_DEC   = {7'b0000000, 2'b01, 2'b01, 2'b00, 2'b00};
  localparam logic [14:0] W_MADR  = {7'b0000000, 2'b10, 2'b01, 2'b00, 2'b00};
  localparam logic [14:0] W_MRD   = {7'b1010000, 2'b00, 2'b00, 2'b00, 2'b00};
  localparam logic [14:0] W_MWB   = {7'b0000001, 2'b00, 2'b00, 2'b00, 2'b01};
  localparam logic [14:0] W_MWR   = {7'b1110000, 2'b00, 2'b00, 2'b00, 2'b00};
  localparam logic [14:0] W_EXR   = {7'b0000000, 2'b10, 2'b00, 2'b10, 2'b00};
  localparam logic [14:0] W_EXI   = {7'b0000000, 2'b10, 2'b01, 2'b11, 2'b00};
  localparam logic [14:0] W_LUI   = {7'b0000000, 2'b11, 2'b01, 2'b00, 2'b00};
  localparam logic [14:0] W_AUI   = {7'b0000000, 2'b01, 2'b01, 2'b00, 2'b00};
  localparam logic [14:0] W_ALUWB = {7'b0000001, 2'b00, 2'b00, 2'b00, 2'b00};
  localparam logic [14:0] W_BR    = {7'b0000010, 2'b10, 2'b00, 2'b01, 2'b00};
  localparam logic [14:0] W_JADR  = {7'b0000000, 2'b10, 2'b01, 2'b00, 2'b00};
  localparam logic [14:0] W_JUMP  = {7'b0000100, 2'b01, 2'b10, 2'b00, 2'b00};

  localparam logic [4:0] LEGAL [9] = '{5'b01100, 5'b00100, 5'b00000, 5'b01000,
                                      5'b11000, 5'b11011, 5'b11001, 5'b01101, 5'b00101};

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One cycle: drive mem_ready, compare everything mid-cycle, move to just after the next edge.
  task automatic step(input logic rdy, input logic [14:0] exp_w);
    mem_ready = rdy;
    @(negedge clk);
    check_eq("ctrl", 32'(cw(mem_req, mem_we, adr_src, ir_write, pc_write, branch,
                            reg_write, alu_src_a, alu_src_b, alu_op, result_src)), 32'(exp_w));
    check_eq("illegal", 32'(illegal), 32'(exp_ill));
    check_eq("bus_err", 32'(bus_err), 32'(exp_berr));
    check_eq("instret", 32'(instret), 32'(exp_ir));
    @(posedge clk);
    #1;
  endtask

  function automatic logic noise();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic do_reset();
    rst_n    = 1'b0;
    exp_ill  = 1'b0;
    exp_berr = 1'b0;
    exp_ir   = 0;
    step(noise(), W_ZERO);
    step(noise(), W_ZERO);
    rst_n = 1'b1;
    step(noise(), W_ZERO);
  endtask

  // A memory request: 'waits' stalled cycles then mem_ready, unless the timeout hits first.
  task automatic req_phase(input logic [14:0] w_wait, input logic [14:0] w_done,
                           input int waits, output bit timed_out);
    timed_out = 1'b0;
    for (int c = 0; c <= TO; c++) begin
      if (c == waits) begin
        step(1'b1, w_done);
        return;
      end
      step(1'b0, w_wait);
      if (c + 1 == TO) begin
        timed_out = 1'b1;
        return;
      end
    end
  endtask

  task automatic trap_tail();
    for (int i = 0; i < 3; i++) step(noise(), W_ZERO);
  endtask

  // Expected per-cycle behaviour of one instruction; returns 1 if it ended in a trap.
  task automatic run_instr(input logic [4:0] opc, input int fw, input int mw, output bit trapped);
    bit   to;
    logic [31:0] r;
    r       = $urandom();
    instr   = {r[31:7], opc, 2'b11};
    trapped = 1'b0;
    req_phase(W_FWAIT, W_FDONE, fw, to);
    if (to) begin
      exp_berr = 1'b1;
      trap_tail();
      trapped = 1'b1;
      return;
    end
    step(noise(), W_DEC);
    case (opc)
      5'b01100: begin step(noise(), W_EXR); step(noise(), W_ALUWB); end
      5'b00100: begin step(noise(), W_EXI); step(noise(), W_ALUWB); end
      5'b01101: begin step(noise(), W_LUI); step(noise(), W_ALUWB); end
      5'b00101: begin step(noise(), W_AUI); step(noise(), W_ALUWB); end
      5'b11000: step(noise(), W_BR);
      5'b11011: begin step(noise(), W_JUMP); step(noise(), W_ALUWB); end
      5'b11001: begin step(noise(), W_JADR); step(noise(), W_JUMP); step(noise(), W_ALUWB); end
      5'b00000, 5'b01000: begin
        step(noise(), W_MADR);
        if (opc == 5'b00000) req_phase(W_MRD, W_MRD, mw, to);
        else                 req_phase(W_MWR, W_MWR, mw, to);
        if (to) begin
          exp_berr = 1'b1;
          trap_tail();
          trapped = 1'b1;
          return;
        end
        if (opc == 5'b00000) step(noise(), W_MWB);
      end
      default: begin
        exp_ill = 1'b1;
        trap_tail();
        trapped = 1'b1;
        return;
      end
    endcase
    exp_ir = (exp_ir + 1) % (1 << CW);
  endtask

  initial begin
    bit t;
    logic [4:0] opc;
    @(posedge clk);
    #1;
    do_reset();

    // Directed: ADD, LW with 3+3 waits, SW, BEQ, JAL, JALR.
    run_instr(5'b01100, 0, 0, t);
    run_instr(5'b00000, 3, 3, t);
    run_instr(5'b01000, 0, 0, t);
    run_instr(5'b11000, 0, 0, t);
    run_instr(5'b11011, 0, 0, t);
    run_instr(5'b11001, 0, 0, t);

    // Random legal instructions with 0..3 wait states; enough to wrap instret.
    for (int i = 0; i < 320; i++) begin
      opc = LEGAL[$urandom_range(0, 8)];
      run_instr(opc, $urandom_range(0, 3), $urandom_range(0, 3), t);
    end

    // Reset in the middle of a stalled store: no request survives the reset.
    run_instr(5'b01100, 0, 0, t);
    instr = {25'h0, 5'b01000, 2'b11};
    step(1'b1, W_FDONE);
    step(noise(), W_DEC);
    step(noise(), W_MADR);
    step(1'b0, W_MWR);
    do_reset();

    // Illegal opcode 1111111: sticky trap, cleared only by reset.
    run_instr(5'b01100, 1, 0, t);
    run_instr(5'b11111, 0, 0, t);
    do_reset();

    // Fetch timeout, then load-data timeout.
    run_instr(5'b00100, 4, 0, t);
    do_reset();
    run_instr(5'b00000, 0, 4, t);
    do_reset();
    run_instr(5'b01000, 2, 6, t);
    do_reset();
    run_instr(5'b01100, 3, 0, t);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
